uart_cmd_bridge: RTL

//  Command endpoint for the UART link. Sits between the UART byte interface
//  (rx_vld/rx_data in, tx_vld/tx_data/txrdy out) and a simple register bus.

---
 rtl/uart_cmd_bridge.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_cmd_bridge.sv
// UART command endpoint: parses 'W' addr data / 'R' addr frames, performs one
// register-bus access per command and returns a single response byte.
module uart_cmd_bridge #(
  parameter int unsigned TIMEOUT = 65535,
  parameter logic [7:0]  OP_WR   = 8'h57,
  parameter logic [7:0]  OP_RD   = 8'h52,
  parameter logic [7:0]  ACK     = 8'h4B,
  parameter logic [7:0]  NAK     = 8'h3F
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_vld_i,
  input  logic [7:0] rx_data_i,
  input  logic       txrdy_i,
  output logic       tx_vld_o,
  output logic [7:0] tx_data_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  input  logic [7:0] reg_rdata_i,
  output logic       rx_drop_o,
  output logic       to_abort_o
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_CAP, SEND, WAIT_LO
  } state_e;

  state_e        state_q;
  logic          isWrite_q;
  logic [7:0]    resp_q;
  logic [7:0]    txData_q;
  logic [7:0]    regAddr_q;
  logic [7:0]    regWdata_q;
  logic          regWr_q;
  logic          regRd_q;
  logic          rxDrop_q;
  logic          toAbort_q;
  logic [CW-1:0] timeoutCnt_q;
  logic          busy;

  assign busy = (state_q == BUS_WR) || (state_q == BUS_RD) || (state_q == RD_CAP) ||
                (state_q == SEND)   || (state_q == WAIT_LO);

  // Strobes are set on the edge that enters BUS_WR/BUS_RD so they line up with those states.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      isWrite_q    <= 1'b0;
      resp_q       <= 8'h00;
      txData_q     <= 8'h00;
      regAddr_q    <= 8'h00;
      regWdata_q   <= 8'h00;
      regWr_q      <= 1'b0;
      regRd_q      <= 1'b0;
      rxDrop_q     <= 1'b0;
      toAbort_q    <= 1'b0;
      timeoutCnt_q <= '0;
    end else begin
      regWr_q   <= 1'b0;
      regRd_q   <= 1'b0;
      toAbort_q <= 1'b0;
      rxDrop_q  <= rx_vld_i && busy;
      case (state_q)
        IDLE: begin
          timeoutCnt_q <= '0;
          if (rx_vld_i) begin
            if ((rx_data_i == OP_WR) || (rx_data_i == OP_RD)) begin
              isWrite_q <= (rx_data_i == OP_WR);
              state_q   <= GET_ADDR;
            end else begin
              resp_q  <= NAK;
              state_q <= SEND;
            end
          end
        end
        GET_ADDR: begin
          if (rx_vld_i) begin
            timeoutCnt_q <= '0;
            regAddr_q    <= rx_data_i;
            if (isWrite_q) begin
              state_q <= GET_DATA;
            end else begin
              regRd_q <= 1'b1;
              state_q <= BUS_RD;
            end
          end else if (timeoutCnt_q == CNT_LAST) begin
            toAbort_q    <= 1'b1;
            timeoutCnt_q <= '0;
            state_q      <= IDLE;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 1'b1;
          end
        end
        GET_DATA: begin
          if (rx_vld_i) begin
            timeoutCnt_q <= '0;
            regWdata_q   <= rx_data_i;
            regWr_q      <= 1'b1;
            state_q      <= BUS_WR;
          end else if (timeoutCnt_q == CNT_LAST) begin
            toAbort_q    <= 1'b1;
            timeoutCnt_q <= '0;
            state_q      <= IDLE;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 1'b1;
          end
        end
        BUS_WR: begin
          resp_q  <= ACK;
          state_q <= SEND;
        end
        BUS_RD: begin
          state_q <= RD_CAP;
        end
        RD_CAP: begin
          resp_q  <= reg_rdata_i;
          state_q <= SEND;
        end
        SEND: begin
          if (txrdy_i) begin
            txData_q <= resp_q;
            state_q  <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!txrdy_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // tx_vld is gated by the live txrdy so it can never fire into a busy transmitter;
  // txData_q keeps the sent byte on the bus until the next send.
  assign tx_vld_o    = (state_q == SEND) && txrdy_i;
  assign tx_data_o   = tx_vld_o ? resp_q : txData_q;
  assign reg_addr_o  = regAddr_q;
  assign reg_wdata_o = regWdata_q;
  assign reg_wr_o    = regWr_q;
  assign reg_rd_o    = regRd_q;
  assign rx_drop_o   = rxDrop_q;
  assign to_abort_o  = toAbort_q;

endmodule
